pipe_stage_elastic: RTL and testbench

- Parametrised inter-stage pipeline register; the next generation of the fixed-payload if/id, id/ex, ex/ls and ls/wb pipe registers.
- Holds up to DEPTH in-flight entries with a valid/ready handshake on both sides. In-ready depends only on registered state, so there is no combinational ready path between stages.
- Adds flush (squash all entries), stall (freeze the output side) and bubble (reject the current input) controls.
- Carries a difftest sideband (pc, instruction) alongside a generic payload.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_ring_buf.sv | 57 +++++
 rtl/pipe_stage_elastic.sv | 81 ++++++++
 tb/tb_pipe_stage_elastic.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic inter-stage pipeline registers.
// Default widths follow the CPU-wide data and instruction widths.
package pipe_pkg;

  localparam int PIPE_CPU_W = 64;
  localparam int PIPE_INS_W = 32;

  localparam int PIPE_DEPTH_MIN = 1;
  localparam int PIPE_DEPTH_MAX = 8;

  // Difftest sideband carried alongside every entry.
  typedef struct packed {
    logic [PIPE_CPU_W-1:0] pc;
    logic [PIPE_INS_W-1:0] ins;
  } pipe_sb_t;

  function automatic bit pipe_depth_legal(input int depth);
    return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/pipe_ring_buf.sv
// Circular entry store with wrap-safe pointers and an occupancy count.
// Push/pop legality is the caller's job; clear empties the buffer.
module pipe_ring_buf
    import pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [W-1:0]     wr_data,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap at DEPTH-1 so non-power-of-2 depths never index past the end.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH)) else $error("ring buffer count above depth");
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !push && count == '0)) else $error("ring buffer pop while empty");
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !clear && count == CNT_W'(DEPTH))) else $error("ring buffer push while full");

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH-entry buffer with registered in-ready,
// plus flush / stall / bubble controls and a difftest sideband.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_CPU_W,
    parameter int PC_W   = PIPE_CPU_W,
    parameter int INS_W  = PIPE_INS_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] i_data,
    input  logic [PC_W-1:0]   s_i_pc,
    input  logic [INS_W-1:0]  s_i_ins,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] o_data,
    output logic [PC_W-1:0]   s_o_pc,
    output logic [INS_W-1:0]  s_o_ins,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_bubble,
    output logic [CNT_W-1:0]  o_count
);

    if (!pipe_depth_legal(DEPTH)) begin : g_depth_check
        $error("pipe_stage_elastic: DEPTH must be within 1..8");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic [INS_W-1:0]  ins;
    } entry_t;

    entry_t           wr_entry;
    entry_t           head;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. ready_o looks only at the registered count and local controls,
    // never at ready_i; valid_o never looks at valid_i, so there is no bypass.
    assign ready_o = (count < CNT_W'(DEPTH)) && !i_bubble && !i_flush;
    assign valid_o = (count != '0) && !i_stall;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    assign wr_entry = '{data: i_data, pc: s_i_pc, ins: s_i_ins};

    pipe_ring_buf #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ring_buf (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .pop     (pop),
        .clear   (i_flush),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count)
    );

    // Head fields read zero whenever nothing is being presented.
    assign o_data  = valid_o ? head.data : '0;
    assign s_o_pc  = valid_o ? head.pc   : '0;
    assign s_o_ins = valid_o ? head.ins  : '0;
    assign o_count = count;

    a_in_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (valid_i && !ready_o && !i_flush) |=> $stable({i_data, s_i_pc, s_i_ins}))
        else $error("upstream payload changed while waiting for ready");

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic at DEPTH=2 and DEPTH=3 with a
// queue-based scoreboard checked by independent head monitors.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=2 instance signals
    logic        v2 = 0, r2 = 0, fl2 = 0, st2 = 0, bu2 = 0;
    logic [63:0] d2 = '0, pc2 = '0;
    logic [31:0] ins2 = '0;
    logic        rdy2, vo2;
    logic [63:0] od2, opc2;
    logic [31:0] oins2;
    logic [1:0]  cnt2;

    // DEPTH=3 instance signals
    logic        v3 = 0, r3 = 0, fl3 = 0, st3 = 0, bu3 = 0;
    logic [63:0] d3 = '0, pc3 = '0;
    logic [31:0] ins3 = '0;
    logic        rdy3, vo3;
    logic [63:0] od3, opc3;
    logic [31:0] oins3;
    logic [1:0]  cnt3;

    logic [159:0] exp_q2[$];
    logic [159:0] exp_q3[$];

    pipe_stage_elastic #(.DEPTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .valid_i(v2), .ready_o(rdy2),
        .i_data(d2), .s_i_pc(pc2), .s_i_ins(ins2), .valid_o(vo2), .ready_i(r2),
        .o_data(od2), .s_o_pc(opc2), .s_o_ins(oins2), .i_flush(fl2),
        .i_stall(st2), .i_bubble(bu2), .o_count(cnt2)
    );

    pipe_stage_elastic #(.DEPTH(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .valid_i(v3), .ready_o(rdy3),
        .i_data(d3), .s_i_pc(pc3), .s_i_ins(ins3), .valid_o(vo3), .ready_i(r3),
        .o_data(od3), .s_o_pc(opc3), .s_o_ins(oins3), .i_flush(fl3),
        .i_stall(st3), .i_bubble(bu3), .o_count(cnt3)
    );

    // Full entry {data, pc, ins} derived from the payload value.
    function automatic logic [159:0] ent(input logic [63:0] d);
        pipe_sb_t sb;
        sb.pc  = d + 64'h1000;
        sb.ins = d[31:0] ^ 32'hA5A5_0000;
        return {d, sb};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [63:0] d);
        v2 = v;
        {d2, pc2, ins2} = ent(d);
    endtask

    task automatic drive3(input logic v, input logic [63:0] d);
        v3 = v;
        {d3, pc3, ins3} = ent(d);
    endtask

    task automatic push_exp2(input logic [63:0] d);
        exp_q2.push_back(ent(d));
    endtask

    // Head monitors: every accepted head must match the front of its queue.
    always @(negedge clk) begin
        logic [159:0] e;
        if (rst_n && vo2 && r2) begin
            if (exp_q2.size() == 0) chk("head2_unexpected", {od2, opc2, oins2}, '0);
            else begin
                e = exp_q2.pop_front();
                chk("head2", {od2, opc2, oins2}, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [159:0] e;
        if (rst_n && vo3 && r3) begin
            if (exp_q3.size() == 0) chk("head3_unexpected", {od3, opc3, oins3}, '0);
            else begin
                e = exp_q3.pop_front();
                chk("head3", {od3, opc3, oins3}, e);
            end
        end
    end

    initial begin
        int     cm;
        logic   pend;
        logic   pu, po;
        logic [63:0] cur_d;

        // Reset
        repeat (3) tick();
        chk("rst_valid", 160'(vo2), 160'd0);
        chk("rst_ready", 160'(rdy2), 160'd1);
        chk("rst_count", 160'(cnt2), 160'd0);
        chk("rst_data", {od2, opc2, oins2}, 160'd0);
        chk("rst_count3", 160'(cnt3), 160'd0);
        rst_n = 1'b1;

        // Basic flow
        r2 = 1;
        drive2(1, 64'h11); push_exp2(64'h11); #1;
        chk("flow_no_bypass", 160'(vo2), 160'd0);
        tick();
        drive2(1, 64'h22); push_exp2(64'h22); #1;
        chk("flow_valid_rise", 160'(vo2), 160'd1);
        chk("flow_ready", 160'(rdy2), 160'd1);
        tick();
        drive2(1, 64'h33); push_exp2(64'h33); #1;
        chk("flow_count", 160'(cnt2), 160'd1);
        chk("flow_ready2", 160'(rdy2), 160'd1);
        tick();
        drive2(0, 0); #1;
        chk("flow_last", 160'(vo2), 160'd1);
        tick();
        chk("flow_empty", 160'(vo2), 160'd0);
        chk("flow_empty_cnt", 160'(cnt2), 160'd0);

        // Backpressure
        r2 = 0;
        drive2(1, 64'h61); push_exp2(64'h61); tick();
        drive2(1, 64'h62); push_exp2(64'h62); tick();
        drive2(1, 64'h63); #1;
        chk("bp_full_ready", 160'(rdy2), 160'd0);
        chk("bp_full_count", 160'(cnt2), 160'd2);
        tick();
        r2 = 1; push_exp2(64'h63); #1;
        chk("bp_no_comb_ready", 160'(rdy2), 160'd0);
        tick();
        chk("bp_after_pop_ready", 160'(rdy2), 160'd1);
        chk("bp_after_pop_cnt", 160'(cnt2), 160'd1);
        tick();
        drive2(0, 0); #1;
        chk("bp_third_in", 160'(cnt2), 160'd1);
        tick();
        chk("bp_drained", 160'(cnt2), 160'd0);

        // Flush with a pending input
        r2 = 0;
        drive2(1, 64'h71); push_exp2(64'h71); tick();
        drive2(1, 64'h72); push_exp2(64'h72); tick();
        drive2(1, 64'h73); fl2 = 1; #1;
        chk("fl_ready", 160'(rdy2), 160'd0);
        tick();
        fl2 = 0; drive2(0, 0); exp_q2.delete(); #1;
        chk("fl_count", 160'(cnt2), 160'd0);
        chk("fl_valid", 160'(vo2), 160'd0);
        r2 = 1;
        drive2(1, 64'h44); push_exp2(64'h44); tick();
        drive2(0, 0); #1;
        chk("fl_next_cnt", 160'(cnt2), 160'd1);
        tick();
        chk("fl_next_drained", 160'(cnt2), 160'd0);

        // Stall
        r2 = 1;
        drive2(1, 64'h81); push_exp2(64'h81); tick();
        st2 = 1; drive2(1, 64'h82); push_exp2(64'h82); #1;
        chk("st_valid", 160'(vo2), 160'd0);
        chk("st_gated", {od2, opc2, oins2}, 160'd0);
        tick();
        drive2(1, 64'h83); #1;
        chk("st_count", 160'(cnt2), 160'd2);
        chk("st_full_ready", 160'(rdy2), 160'd0);
        tick();
        chk("st_hold", 160'(cnt2), 160'd2);
        chk("st_valid3", 160'(vo2), 160'd0);
        tick();
        st2 = 0; push_exp2(64'h83); #1;
        chk("st_release", 160'(vo2), 160'd1);
        tick();
        chk("st_pop1", 160'(cnt2), 160'd1);
        tick();
        drive2(0, 0); #1;
        chk("st_push83", 160'(cnt2), 160'd1);
        tick();
        chk("st_drained", 160'(cnt2), 160'd0);

        // Bubble
        drive2(1, 64'h55); bu2 = 1; #1;
        chk("bu_ready", 160'(rdy2), 160'd0);
        tick();
        bu2 = 0; push_exp2(64'h55); #1;
        chk("bu_ready_back", 160'(rdy2), 160'd1);
        chk("bu_not_taken", 160'(cnt2), 160'd0);
        tick();
        drive2(0, 0); #1;
        chk("bu_taken", 160'(cnt2), 160'd1);
        tick();
        chk("bu_drained", 160'(cnt2), 160'd0);
        tick();
        chk("bu_once", 160'(vo2), 160'd0);

        // DEPTH=3 random traffic with a reference count model
        cm = 0; pend = 0; cur_d = '0;
        for (int i = 0; i < 48; i++) begin
            if (i >= 40) begin
                cur_d = '0; drive3(0, cur_d); r3 = 1; pend = 0;
            end else begin
                if (!pend) begin
                    cur_d = 64'h300 + 64'(i);
                    drive3($urandom_range(0, 3) != 0, cur_d);
                end
                r3 = ($urandom_range(0, 2) != 0);
            end
            #1;
            chk("d3_count", 160'(cnt3), 160'(cm));
            chk("d3_ready", 160'(rdy3), 160'(cm < 3));
            chk("d3_valid", 160'(vo3), 160'(cm != 0));
            pu = v3 && (cm < 3);
            po = (cm != 0) && r3;
            if (pu) exp_q3.push_back(ent(cur_d));
            pend = v3 && !pu;
            cm = cm + int'(pu) - int'(po);
            tick();
        end

        chk("q2_empty", 160'(exp_q2.size()), 160'd0);
        chk("q3_empty", 160'(exp_q3.size()), 160'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
